regra_disparo_t2: RTL and testbench

Sequential rule-firing stage for the two-input interval type-2 fuzzy controller. It sits directly downstream of the FOU fuzzifier and takes a snapshot of the twelve upper/lower membership grades and the 6-bit activity vector. It then walks the 3×3 rule base one rule per enabled cycle, emitting each rule's upper and lower firing interval for the type-reduction stage.

---
 rtl/fuzzy_t2_pkg.sv | 32 +++
 rtl/t_norm.sv | 25 ++
 rtl/regra_disparo_t2.sv | 142 ++++++++++++++
 tb/tb_regra_disparo_t2.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_t2_pkg.sv
// Shared types, constants and helpers for the interval type-2 fuzzy controller.
// Holds the rule-base geometry, the FSM state set and the t-norm select codes.
package fuzzy_t2_pkg;

    localparam int N_SETS  = 3;
    localparam int N_RULES = 9;
    localparam int W       = 8;

    localparam int TN_MIN  = 0;
    localparam int TN_PROD = 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SCAN,
        DONE
    } state_t;

    typedef struct packed {
        logic [1:0] i;
        logic [1:0] j;
    } rule_ij_t;

    // Rule k = 3*i + j : i picks the input-1 set, j the input-2 set.
    function automatic rule_ij_t rule_ij(input logic [3:0] k);
        rule_ij_t r;
        r.i = 2'(k / 4'd3);
        r.j = 2'(k % 4'd3);
        return r;
    endfunction

endpackage

// File: rtl/t_norm.sv
// Combinational two-input t-norm: minimum, or rounded-up product (a*b + max) >> W.
// Ports: i_a, i_b grades in; o_y grade out.
module t_norm #(
    parameter int T_NORM = 0,
    parameter int W      = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);
    import fuzzy_t2_pkg::*;

    generate
        if (T_NORM == TN_PROD) begin : g_prod
            logic [2*W-1:0] w_sum;
            // Adding all-ones before the shift makes 255*255 map back to 255.
            assign w_sum = ({{W{1'b0}}, i_a} * {{W{1'b0}}, i_b})
                         + {{W{1'b0}}, {W{1'b1}}};
            assign o_y   = W'(w_sum >> W);
        end else begin : g_min
            assign o_y = (i_a < i_b) ? i_a : i_b;
        end
    endgenerate

endmodule

// File: rtl/regra_disparo_t2.sv
// Sequential 3x3 rule-firing stage: snapshots the FOU grades and walks one rule per enabled cycle.
// Ports: clk/RESET/EN_SCLK/START control; FOU_* grades, Ativo_UP flags in; Regra_idx, Firing_*, N_ativas, Busy, Done out.
module regra_disparo_t2 #(
    parameter int T_NORM = 0,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         EN_SCLK,
    input  logic         START,
    input  logic [W-1:0] FOU_01_UP,
    input  logic [W-1:0] FOU_01_LOW,
    input  logic [W-1:0] FOU_02_UP,
    input  logic [W-1:0] FOU_02_LOW,
    input  logic [W-1:0] FOU_03_UP,
    input  logic [W-1:0] FOU_03_LOW,
    input  logic [W-1:0] FOU_04_UP,
    input  logic [W-1:0] FOU_04_LOW,
    input  logic [W-1:0] FOU_05_UP,
    input  logic [W-1:0] FOU_05_LOW,
    input  logic [W-1:0] FOU_06_UP,
    input  logic [W-1:0] FOU_06_LOW,
    input  logic [5:0]   Ativo_UP,
    output logic [3:0]   Regra_idx,
    output logic [W-1:0] Firing_UP,
    output logic [W-1:0] Firing_LOW,
    output logic         Firing_valid,
    output logic [3:0]   N_ativas,
    output logic         Busy,
    output logic         Done
);
    import fuzzy_t2_pkg::*;

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_cnt;
    logic [W-1:0] r_up1  [N_SETS];
    logic [W-1:0] r_low1 [N_SETS];
    logic [W-1:0] r_up2  [N_SETS];
    logic [W-1:0] r_low2 [N_SETS];
    logic [2:0]   r_act1;
    logic [2:0]   r_act2;

    rule_ij_t     w_ij;
    logic         w_act;
    logic [W-1:0] w_tu;
    logic [W-1:0] w_tl;
    logic [W-1:0] w_low_c;

    assign w_ij  = rule_ij(r_cnt);
    assign w_act = r_act1[w_ij.i] & r_act2[w_ij.j];

    t_norm #(.T_NORM(T_NORM), .W(W)) u_tn_up (
        .i_a (r_up1[w_ij.i]),
        .i_b (r_up2[w_ij.j]),
        .o_y (w_tu)
    );

    t_norm #(.T_NORM(T_NORM), .W(W)) u_tn_low (
        .i_a (r_low1[w_ij.i]),
        .i_b (r_low2[w_ij.j]),
        .o_y (w_tl)
    );

    // Keep the interval well formed even if the fuzzifier hands us LOW > UP.
    assign w_low_c = (w_tl > w_tu) ? w_tu : w_tl;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) r_state <= IDLE;
        else if (EN_SCLK) r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (START) w_next = CAPTURE;
            CAPTURE: w_next = SCAN;
            SCAN:    if (r_cnt == 4'(N_RULES - 1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_cnt        <= '0;
            r_act1       <= '0;
            r_act2       <= '0;
            for (int s = 0; s < N_SETS; s++) begin
                r_up1[s]  <= '0;
                r_low1[s] <= '0;
                r_up2[s]  <= '0;
                r_low2[s] <= '0;
            end
            Regra_idx    <= '0;
            Firing_UP    <= '0;
            Firing_LOW   <= '0;
            Firing_valid <= 1'b0;
            N_ativas     <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else if (EN_SCLK) begin
            Busy <= (r_state != IDLE);
            Done <= (r_state == DONE);
            case (r_state)
                CAPTURE: begin
                    r_up1[0]     <= FOU_01_UP;
                    r_up1[1]     <= FOU_02_UP;
                    r_up1[2]     <= FOU_03_UP;
                    r_low1[0]    <= FOU_01_LOW;
                    r_low1[1]    <= FOU_02_LOW;
                    r_low1[2]    <= FOU_03_LOW;
                    r_up2[0]     <= FOU_04_UP;
                    r_up2[1]     <= FOU_05_UP;
                    r_up2[2]     <= FOU_06_UP;
                    r_low2[0]    <= FOU_04_LOW;
                    r_low2[1]    <= FOU_05_LOW;
                    r_low2[2]    <= FOU_06_LOW;
                    // Bit 5 of Ativo_UP is set 01, so reverse into set order.
                    r_act1       <= {Ativo_UP[3], Ativo_UP[4], Ativo_UP[5]};
                    r_act2       <= {Ativo_UP[0], Ativo_UP[1], Ativo_UP[2]};
                    r_cnt        <= '0;
                    N_ativas     <= '0;
                    Firing_valid <= 1'b0;
                end
                SCAN: begin
                    Regra_idx    <= r_cnt;
                    Firing_UP    <= w_act ? w_tu : '0;
                    Firing_LOW   <= w_act ? w_low_c : '0;
                    Firing_valid <= w_act;
                    N_ativas     <= N_ativas + {3'b000, w_act};
                    r_cnt        <= r_cnt + 4'd1;
                end
                DONE: begin
                    Firing_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regra_disparo_t2.sv
// Randomized bench for regra_disparo_t2 with min and product instances side by side.
// Expected firings come from a rule-table model of the controller's rule base.
module tb_regra_disparo_t2;

    logic       clk = 1'b0;
    logic       RESET;
    logic       EN_SCLK;
    logic       START;
    logic [7:0] up  [6];
    logic [7:0] low [6];
    logic [5:0] act;

    logic [3:0] idx  [2];
    logic [7:0] fu   [2];
    logic [7:0] fl   [2];
    logic       val  [2];
    logic [3:0] n    [2];
    logic       busy [2];
    logic       done [2];

    logic [7:0] s_up  [6];
    logic [7:0] s_low [6];
    logic [5:0] s_act;

    int got_up  [2][9];
    int got_low [2][9];
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    regra_disparo_t2 #(.T_NORM(0), .W(8)) u_min (
        .clk(clk), .RESET(RESET), .EN_SCLK(EN_SCLK), .START(START),
        .FOU_01_UP(up[0]), .FOU_01_LOW(low[0]),
        .FOU_02_UP(up[1]), .FOU_02_LOW(low[1]),
        .FOU_03_UP(up[2]), .FOU_03_LOW(low[2]),
        .FOU_04_UP(up[3]), .FOU_04_LOW(low[3]),
        .FOU_05_UP(up[4]), .FOU_05_LOW(low[4]),
        .FOU_06_UP(up[5]), .FOU_06_LOW(low[5]),
        .Ativo_UP(act),
        .Regra_idx(idx[0]), .Firing_UP(fu[0]), .Firing_LOW(fl[0]),
        .Firing_valid(val[0]), .N_ativas(n[0]),
        .Busy(busy[0]), .Done(done[0])
    );

    regra_disparo_t2 #(.T_NORM(1), .W(8)) u_prod (
        .clk(clk), .RESET(RESET), .EN_SCLK(EN_SCLK), .START(START),
        .FOU_01_UP(up[0]), .FOU_01_LOW(low[0]),
        .FOU_02_UP(up[1]), .FOU_02_LOW(low[1]),
        .FOU_03_UP(up[2]), .FOU_03_LOW(low[2]),
        .FOU_04_UP(up[3]), .FOU_04_LOW(low[3]),
        .FOU_05_UP(up[4]), .FOU_05_LOW(low[4]),
        .FOU_06_UP(up[5]), .FOU_06_LOW(low[5]),
        .Ativo_UP(act),
        .Regra_idx(idx[1]), .Firing_UP(fu[1]), .Firing_LOW(fl[1]),
        .Firing_valid(val[1]), .N_ativas(n[1]),
        .Busy(busy[1]), .Done(done[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int tn(input int mode, input int a, input int b);
        if (mode == 1) return (a * b + 255) / 256;
        return (a < b) ? a : b;
    endfunction

    function automatic void model(input int mode, input int k,
                                  output int eu, output int el,
                                  output int ea);
        int i = k / 3;
        int j = k % 3;
        ea = (s_act[5 - i] && s_act[2 - j]) ? 1 : 0;
        eu = tn(mode, s_up[i], s_up[3 + j]);
        el = tn(mode, s_low[i], s_low[3 + j]);
        if (el > eu) el = eu;
        if (ea == 0) begin
            eu = 0;
            el = 0;
        end
    endfunction

    task automatic scramble();
        for (int s = 0; s < 6; s++) begin
            up[s]  = 8'($urandom);
            low[s] = 8'($urandom);
        end
        act = 6'($urandom);
    endtask

    task automatic check_rule(input int k, input int nexp);
        int eu, el, ea;
        for (int d = 0; d < 2; d++) begin
            model(d, k, eu, el, ea);
            chk($sformatf("d%0d_r%0d_idx", d, k), idx[d], k);
            chk($sformatf("d%0d_r%0d_valid", d, k), val[d], ea);
            chk($sformatf("d%0d_r%0d_up", d, k), fu[d], eu);
            chk($sformatf("d%0d_r%0d_low", d, k), fl[d], el);
            chk($sformatf("d%0d_r%0d_n", d, k), n[d], nexp);
            chk($sformatf("d%0d_r%0d_busy", d, k), busy[d], 1);
            chk($sformatf("d%0d_r%0d_done", d, k), done[d], 0);
            got_up[d][k]  = fu[d];
            got_low[d][k] = fl[d];
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_idx", tag, d), idx[d], 0);
            chk($sformatf("%s_d%0d_up", tag, d), fu[d], 0);
            chk($sformatf("%s_d%0d_low", tag, d), fl[d], 0);
            chk($sformatf("%s_d%0d_valid", tag, d), val[d], 0);
            chk($sformatf("%s_d%0d_n", tag, d), n[d], 0);
            chk($sformatf("%s_d%0d_busy", tag, d), busy[d], 0);
            chk($sformatf("%s_d%0d_done", tag, d), done[d], 0);
        end
    endtask

    task automatic run_eval(input int gap_k, input int rst_k);
        int nexp = 0;
        int eu, el, ea;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("busy_start", busy[0], 0);
        s_up  = up;
        s_low = low;
        s_act = act;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_busy_cap", d), busy[d], 1);
            chk($sformatf("d%0d_n_cap", d), n[d], 0);
        end
        scramble();
        for (int k = 0; k < 9; k++) begin
            START = (k < 8) ? 1'($urandom) : 1'b0;
            tick();
            model(0, k, eu, el, ea);
            nexp += ea;
            check_rule(k, nexp);
            if (k == gap_k) begin
                EN_SCLK = 1'b0;
                repeat (5) begin
                    scramble();
                    START = 1'b1;
                    tick();
                    check_rule(k, nexp);
                end
                START   = 1'b0;
                EN_SCLK = 1'b1;
            end
            if (k == rst_k) begin
                START = 1'b0;
                RESET = 1'b1;
                #1;
                check_zero("rst_mid");
                RESET = 1'b0;
                return;
            end
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_done_hi", d), done[d], 1);
            chk($sformatf("d%0d_busy_done", d), busy[d], 1);
            chk($sformatf("d%0d_valid_done", d), val[d], 0);
            chk($sformatf("d%0d_n_done", d), n[d], nexp);
            chk($sformatf("d%0d_idx_done", d), idx[d], 8);
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_done_lo", d), done[d], 0);
            chk($sformatf("d%0d_busy_idle", d), busy[d], 0);
            chk($sformatf("d%0d_n_hold", d), n[d], nexp);
        end
    endtask

    initial begin
        RESET   = 1'b1;
        EN_SCLK = 1'b1;
        START   = 1'b0;
        for (int s = 0; s < 6; s++) begin
            up[s]  = '0;
            low[s] = '0;
        end
        act = '0;
        tick();
        tick();
        check_zero("reset");
        RESET = 1'b0;
        tick();

        up[0] = 200; up[1] = 50;  up[2] = 0;
        up[3] = 120; up[4] = 255; up[5] = 10;
        for (int s = 0; s < 6; s++) low[s] = (up[s] >= 10) ? up[s] - 8'd10 : 8'd0;
        act = 6'b111111;
        run_eval(-1, -1);
        chk("min_r1_up", got_up[0][1], 200);
        chk("min_r1_low", got_low[0][1], 190);
        chk("min_r3_up", got_up[0][3], 50);
        chk("min_r3_low", got_low[0][3], 40);
        chk("min_all_n", n[0], 9);

        scramble();
        act = 6'b010010;
        run_eval(-1, -1);
        chk("sparse_n", n[0], 1);

        scramble();
        act = 6'b111111;
        up[0] = 255; up[3] = 255; up[1] = 0;
        run_eval(-1, -1);
        chk("prod_255", got_up[1][0], 255);
        chk("prod_zero", got_up[1][3], 0);

        up[0] = 128; up[3] = 128;
        run_eval(-1, -1);
        chk("prod_128", got_up[1][0], 64);

        scramble();
        act = 6'b111111;
        low[1] = 180; up[1] = 100; up[4] = 255; low[4] = 255;
        run_eval(-1, -1);
        chk("clamp_min_up", got_up[0][4], 100);
        chk("clamp_min_low", got_low[0][4], 100);
        chk("clamp_prod_low", got_low[1][4], 100);

        scramble();
        run_eval(3, -1);

        scramble();
        run_eval(-1, 5);
        scramble();
        run_eval(-1, -1);

        for (int r = 0; r < 20; r++) begin
            scramble();
            run_eval(($urandom % 3 == 0) ? int'($urandom % 9) : -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
